// File: rtl/address_latch_bank_pkg.sv
// -----------------------------------------------------------------------------
// address_latch_bank_pkg
// Shared definitions for the multi-channel address latch bank.
//   - Default address width and channel count
//   - Operation codes driven on the op field
//   - Encoding of the two-byte-load sequencer states
// No ports (package).
// -----------------------------------------------------------------------------
package address_latch_bank_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_CH = 4;

    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_INC   = 3'd2;
    localparam logic [2:0] OP_DEC   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_LOAD2 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2
    } load2_state_t;

endpackage

// File: rtl/address_latch_bank_if.sv
// -----------------------------------------------------------------------------
// address_latch_bank_if
// Bus bundle between a controller (master) and the latch bank (slave).
//   i_en         operation strobe
//   i_op         operation code
//   i_ch_sel     target channel of the operation
//   i_din        full-width load data
//   i_byte_in    data-bus byte (ADD offset / two-byte-load payload)
//   i_byte_valid i_byte_in carries a valid two-byte-load byte
//   i_out_sel    channel driven onto o_addr_out
//   o_addr_out   contents of channel i_out_sel
//   o_busy       two-byte load in progress
//   o_wrap       previous operation wrapped modulo 2^AW
// -----------------------------------------------------------------------------
interface address_latch_bank_if #(
    parameter int AW = address_latch_bank_pkg::DEFAULT_AW,
    parameter int CH = address_latch_bank_pkg::DEFAULT_CH
);
    localparam int CW = $clog2(CH);

    logic          i_en;
    logic [2:0]    i_op;
    logic [CW-1:0] i_ch_sel;
    logic [AW-1:0] i_din;
    logic [7:0]    i_byte_in;
    logic          i_byte_valid;
    logic [CW-1:0] i_out_sel;
    logic [AW-1:0] o_addr_out;
    logic          o_busy;
    logic          o_wrap;

    modport master (
        output i_en, i_op, i_ch_sel, i_din, i_byte_in, i_byte_valid, i_out_sel,
        input  o_addr_out, o_busy, o_wrap
    );

    modport slave (
        input  i_en, i_op, i_ch_sel, i_din, i_byte_in, i_byte_valid, i_out_sel,
        output o_addr_out, o_busy, o_wrap
    );

endinterface

// File: rtl/address_latch_bank_alu.sv
// -----------------------------------------------------------------------------
// address_alu
// Combinational next-value computation for one address channel.
//   i_cur   current channel value
//   i_op    operation code
//   i_din   full-width load data
//   i_byte  signed 8-bit offset for ADD
//   o_next  value to write back (i_cur for HOLD / reserved / LOAD2)
//   o_wrap  result wrapped modulo 2^AW
// -----------------------------------------------------------------------------
module address_alu
    import address_latch_bank_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic [AW-1:0] i_cur,
    input  logic [2:0]    i_op,
    input  logic [AW-1:0] i_din,
    input  logic [7:0]    i_byte,
    output logic [AW-1:0] o_next,
    output logic          o_wrap
);

    logic [AW-1:0] w_ofs;
    logic [AW:0]   w_sum;

    assign w_ofs = {{(AW-8){i_byte[7]}}, i_byte};

    // Operation decode; bit AW of the extended sum is the carry/borrow.
    always_comb begin
        w_sum  = '0;
        o_next = i_cur;
        o_wrap = 1'b0;
        case (i_op)
            OP_LOAD: begin
                o_next = i_din;
            end
            OP_INC: begin
                w_sum  = {1'b0, i_cur} + {{AW{1'b0}}, 1'b1};
                o_next = w_sum[AW-1:0];
                o_wrap = w_sum[AW];
            end
            OP_DEC: begin
                w_sum  = {1'b0, i_cur} - {{AW{1'b0}}, 1'b1};
                o_next = w_sum[AW-1:0];
                o_wrap = w_sum[AW];
            end
            OP_ADD: begin
                // A negative offset is added as its two's complement, so the
                // absence of a carry is what signals a borrow past zero.
                w_sum  = {1'b0, i_cur} + {1'b0, w_ofs};
                o_next = w_sum[AW-1:0];
                o_wrap = w_sum[AW] ^ i_byte[7];
            end
            default: begin
                o_next = i_cur;
                o_wrap = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/address_latch_bank.sv
// -----------------------------------------------------------------------------
// address_latch_bank
// CH independent AW-bit address registers with load / inc / dec / offset-add
// and an atomic two-byte load from the 8-bit data bus.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    address_latch_bank_if.slave (strobe, op, selects, data, outputs)
// -----------------------------------------------------------------------------
module address_latch_bank
    import address_latch_bank_pkg::*;
#(
    parameter int            AW        = DEFAULT_AW,
    parameter int            CH        = DEFAULT_CH,
    parameter logic [AW-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    address_latch_bank_if.slave bus
);

    localparam int          CW   = $clog2(CH);
    localparam logic [CW:0] CH_L = (CW+1)'(CH);

    logic [AW-1:0] r_ch [CH];
    load2_state_t  r_state;
    logic [CW-1:0] r_target;
    logic [7:0]    r_lo;
    logic          r_busy;
    logic          r_wrap;

    load2_state_t  w_state_nxt;
    logic          w_wr;
    logic [CW-1:0] w_wr_idx;
    logic [AW-1:0] w_wr_data;
    logic          w_lo_we;
    logic          w_tgt_we;
    logic          w_wrap_nxt;
    logic [AW-1:0] w_alu_cur;
    logic [AW-1:0] w_alu_next;
    logic          w_alu_wrap;

    // Selected channel value fed to the ALU; non-existent channels read as zero.
    always_comb begin
        if ({1'b0, bus.i_ch_sel} < CH_L) begin
            w_alu_cur = r_ch[bus.i_ch_sel];
        end else begin
            w_alu_cur = '0;
        end
    end

    address_alu #(.AW(AW)) u_alu (
        .i_cur  (w_alu_cur),
        .i_op   (bus.i_op),
        .i_din  (bus.i_din),
        .i_byte (bus.i_byte_in),
        .o_next (w_alu_next),
        .o_wrap (w_alu_wrap)
    );

    // Next-state and write controls; strobes outside IDLE are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_idx    = bus.i_ch_sel;
        w_wr_data   = w_alu_next;
        w_lo_we     = 1'b0;
        w_tgt_we    = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_en && (bus.i_op == OP_LOAD2)) begin
                    w_tgt_we    = 1'b1;
                    w_state_nxt = ST_WAIT_LO;
                end else if (bus.i_en) begin
                    w_wr       = 1'b1;
                    w_wrap_nxt = w_alu_wrap;
                end else begin
                    w_wr = 1'b0;
                end
            end
            ST_WAIT_LO: begin
                if (bus.i_byte_valid) begin
                    w_lo_we     = 1'b1;
                    w_state_nxt = ST_WAIT_HI;
                end else begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (bus.i_byte_valid) begin
                    // Single full-width write keeps the load atomic.
                    w_wr        = 1'b1;
                    w_wr_idx    = r_target;
                    w_wr_data   = {bus.i_byte_in[AW-9:0], r_lo};
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latched target, low-byte temp and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_lo     <= 8'h00;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_wrap  <= w_wrap_nxt;
            if (w_tgt_we) begin
                r_target <= bus.i_ch_sel;
            end
            if (w_lo_we) begin
                r_lo <= bus.i_byte_in;
            end
        end
    end

    // Channel array: only the addressed channel is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_ch[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_wr && (w_wr_idx == CW'(i))) begin
                    r_ch[i] <= w_wr_data;
                end
            end
        end
    end

    // Output mux is combinational so out_sel changes show the same cycle.
    always_comb begin
        if ({1'b0, bus.i_out_sel} < CH_L) begin
            bus.o_addr_out = r_ch[bus.i_out_sel];
        end else begin
            bus.o_addr_out = '0;
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_wrap = r_wrap;

endmodule

// File: tb/tb_address_latch_bank.sv
// -----------------------------------------------------------------------------
// tb_address_latch_bank
// Directed vector table plus hand-written two-byte-load and reset sequences.
// -----------------------------------------------------------------------------
module tb_address_latch_bank;
    import address_latch_bank_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    address_latch_bank_if #(.AW(16), .CH(4)) bus ();

    address_latch_bank #(.AW(16), .CH(4), .RESET_VAL(16'h0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [1:0]  ch;
        logic [15:0] din;
        logic [7:0]  b;
        logic [1:0]  os;
        logic [15:0] ea;
        logic        ew;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_en = 1'b0; bus.i_op = OP_HOLD; bus.i_ch_sel = 2'd0;
        bus.i_din = 16'h0000; bus.i_byte_in = 8'h00; bus.i_byte_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int k = 0; k < 4; k++) begin
            bus.i_out_sel = 2'(k);
            #1;
            chk($sformatf("%s_ch%0d", tag, k), bus.o_addr_out, exp[k]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        bus.i_out_sel = 2'd0;
        rst_n = 1'b0;

        vecs[0]  = '{1'b1, OP_LOAD, 2'd0, 16'hFFFF, 8'h00, 2'd0, 16'hFFFF, 1'b0};
        vecs[1]  = '{1'b1, OP_HOLD, 2'd1, 16'h0000, 8'h00, 2'd1, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, OP_INC,  2'd0, 16'h0000, 8'h00, 2'd0, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, OP_HOLD, 2'd0, 16'h0000, 8'h00, 2'd0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, OP_DEC,  2'd1, 16'h0000, 8'h00, 2'd1, 16'hFFFF, 1'b1};
        vecs[5]  = '{1'b1, OP_LOAD, 2'd2, 16'h0010, 8'h00, 2'd2, 16'h0010, 1'b0};
        vecs[6]  = '{1'b1, OP_INC,  2'd2, 16'h0000, 8'h00, 2'd2, 16'h0011, 1'b0};
        vecs[7]  = '{1'b1, OP_LOAD, 2'd3, 16'h0100, 8'h00, 2'd3, 16'h0100, 1'b0};
        vecs[8]  = '{1'b1, OP_ADD,  2'd3, 16'h0000, 8'hF0, 2'd3, 16'h00F0, 1'b0};
        vecs[9]  = '{1'b1, OP_ADD,  2'd3, 16'h0000, 8'h7F, 2'd3, 16'h016F, 1'b0};
        vecs[10] = '{1'b1, OP_ADD,  2'd1, 16'h0000, 8'h01, 2'd1, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, OP_INC,  2'd1, 16'h0000, 8'h00, 2'd1, 16'h0000, 1'b0};
        vecs[12] = '{1'b1, 3'd6,    2'd2, 16'hABCD, 8'h00, 2'd2, 16'h0011, 1'b0};
        vecs[13] = '{1'b1, OP_ADD,  2'd3, 16'h0000, 8'h80, 2'd3, 16'h00EF, 1'b0};
        vecs[14] = '{1'b1, OP_ADD,  2'd0, 16'h0000, 8'hFF, 2'd0, 16'hFFFF, 1'b1};
        vecs[15] = '{1'b1, OP_DEC,  2'd2, 16'h0000, 8'h00, 2'd2, 16'h0010, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", {15'd0, bus.o_busy}, 16'h0000);
        chk("rst_wrap", {15'd0, bus.o_wrap}, 16'h0000);
        check_all("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven single-cycle operations
        for (int i = 0; i < 16; i++) begin
            bus.i_en = vecs[i].en; bus.i_op = vecs[i].op; bus.i_ch_sel = vecs[i].ch;
            bus.i_din = vecs[i].din; bus.i_byte_in = vecs[i].b; bus.i_out_sel = vecs[i].os;
            tick();
            chk($sformatf("vec%0d_addr", i), bus.o_addr_out, vecs[i].ea);
            chk($sformatf("vec%0d_wrap", i), {15'd0, bus.o_wrap}, {15'd0, vecs[i].ew});
        end
        idle_inputs();
        tick();
        chk("wrap_clears", {15'd0, bus.o_wrap}, 16'h0000);
        check_all("tbl", 16'hFFFF, 16'h0000, 16'h0010, 16'h00EF);

        // LOAD2 ch2 with gapped bytes and ignored strobes while busy
        bus.i_out_sel = 2'd2;
        bus.i_en = 1'b1; bus.i_op = OP_LOAD2; bus.i_ch_sel = 2'd2;
        tick();
        chk("l2_start_busy", {15'd0, bus.o_busy}, 16'h0001);
        chk("l2_start_addr", bus.o_addr_out, 16'h0010);
        bus.i_en = 1'b0; bus.i_byte_in = 8'h34; bus.i_byte_valid = 1'b1;
        tick();
        chk("l2_lo_busy", {15'd0, bus.o_busy}, 16'h0001);
        chk("l2_lo_addr", bus.o_addr_out, 16'h0010);
        bus.i_byte_valid = 1'b0; bus.i_byte_in = 8'h00;
        bus.i_en = 1'b1; bus.i_op = OP_LOAD; bus.i_din = 16'hBEEF; bus.i_ch_sel = 2'd2;
        tick();
        chk("l2_gap1_busy", {15'd0, bus.o_busy}, 16'h0001);
        chk("l2_gap1_addr", bus.o_addr_out, 16'h0010);
        bus.i_op = OP_INC; bus.i_ch_sel = 2'd0;
        tick();
        chk("l2_gap2_busy", {15'd0, bus.o_busy}, 16'h0001);
        chk("l2_gap2_addr", bus.o_addr_out, 16'h0010);
        chk("l2_gap2_wrap", {15'd0, bus.o_wrap}, 16'h0000);
        bus.i_en = 1'b0; bus.i_ch_sel = 2'd1;
        bus.i_byte_in = 8'h12; bus.i_byte_valid = 1'b1;
        tick();
        chk("l2_hi_busy", {15'd0, bus.o_busy}, 16'h0000);
        chk("l2_hi_addr", bus.o_addr_out, 16'h1234);
        // New op accepted on the edge right after busy falls
        idle_inputs();
        bus.i_en = 1'b1; bus.i_op = OP_INC; bus.i_ch_sel = 2'd2;
        tick();
        chk("post_l2_inc", bus.o_addr_out, 16'h1235);
        idle_inputs();
        check_all("l2", 16'hFFFF, 16'h0000, 16'h1235, 16'h00EF);

        // LOAD2 ch1 at minimum latency; start-edge byte is ignored
        bus.i_out_sel = 2'd1;
        bus.i_en = 1'b1; bus.i_op = OP_LOAD2; bus.i_ch_sel = 2'd1;
        bus.i_byte_valid = 1'b1; bus.i_byte_in = 8'h99;
        tick();
        bus.i_en = 1'b0; bus.i_byte_in = 8'hCD;
        tick();
        chk("fast_lo_addr", bus.o_addr_out, 16'h0000);
        bus.i_byte_in = 8'hAB;
        tick();
        chk("fast_hi_addr", bus.o_addr_out, 16'hABCD);
        chk("fast_hi_busy", {15'd0, bus.o_busy}, 16'h0000);
        idle_inputs();

        // Reset between low and high byte aborts the load
        bus.i_out_sel = 2'd3;
        bus.i_en = 1'b1; bus.i_op = OP_LOAD2; bus.i_ch_sel = 2'd3;
        tick();
        bus.i_en = 1'b0; bus.i_byte_in = 8'h56; bus.i_byte_valid = 1'b1;
        tick();
        bus.i_byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {15'd0, bus.o_busy}, 16'h0000);
        check_all("abort", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_byte_in = 8'h78; bus.i_byte_valid = 1'b1;
        tick();
        tick();
        chk("abort_after_busy", {15'd0, bus.o_busy}, 16'h0000);
        check_all("abort_after", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
